// File: rtl/jtframe_cen_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : jtframe_cen_pkg
//  Purpose  : Shared ratio constants and default widths for the fractional
//             clock-enable dividers fed by the 48 MHz cen generator.
//  Revision : 1.0 - initial release
// ============================================================================
package jtframe_cen_pkg;

  localparam int CEN_DEF_W  = 11;

  // 3.579545 MHz (NTSC colour burst) and half of it, both from 48 MHz
  localparam int CEN_3P57_N = 105;
  localparam int CEN_3P57_M = 1408;
  localparam int CEN_1P78_N = 105;
  localparam int CEN_1P78_M = 2816;

endpackage
`default_nettype wire

// File: rtl/jtframe_frac_cen_meas.sv
`default_nettype none
// ============================================================================
//  Module   : jtframe_frac_cen_meas
//  Purpose  : Counts cen pulses over a window of 2^MEASW cen_in strobes and
//             reports the saturated count once per window.
//  Revision : 1.0 - initial release
// ============================================================================
module jtframe_frac_cen_meas
  import jtframe_cen_pkg::*;
#(
  parameter int MEASW = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cen_in,
  input  logic             pause,
  input  logic             cen,
  output logic [MEASW-1:0] meas,
  output logic             meas_vld
);

  logic [MEASW-1:0] r_win;
  logic [MEASW:0]   r_pcnt;
  logic [MEASW:0]   w_pcnt_nxt;
  logic             w_wrap;

  // One extra bit: a window can hold one more pulse than all-ones
  assign w_pcnt_nxt = r_pcnt + (MEASW+1)'(cen);
  assign w_wrap     = cen_in && (&r_win);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_win    <= '0;
      r_pcnt   <= '0;
      meas     <= '0;
      meas_vld <= 1'b0;
    end else begin
      meas_vld <= 1'b0;
      if (!pause) begin
        if (cen_in) r_win <= r_win + MEASW'(1);
        if (w_wrap) begin
          meas     <= w_pcnt_nxt[MEASW] ? '1 : w_pcnt_nxt[MEASW-1:0];
          meas_vld <= 1'b1;
          r_pcnt   <= '0;
        end else begin
          r_pcnt   <= w_pcnt_nxt;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/jtframe_frac_cen.sv
`default_nettype none
// ============================================================================
//  Module   : jtframe_frac_cen
//  Purpose  : Fractional clock enable, cen = cen_in * n / m, plus alternating
//             half-rate pair cen2/cen2b. Optional rate measurement output
//             enabled by JTFRAME_FRAC_CEN_MEAS_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module jtframe_frac_cen
  import jtframe_cen_pkg::*;
#(
  parameter int W = CEN_DEF_W
`ifdef JTFRAME_FRAC_CEN_MEAS_EN
  , parameter int MEASW = 16
`endif
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cen_in,
  input  logic [W-1:0] n,
  input  logic [W-1:0] m,
  input  logic         pause,
  output logic         cen,
  output logic         cen2,
  output logic         cen2b
`ifdef JTFRAME_FRAC_CEN_MEAS_EN
  , output logic [MEASW-1:0] meas
  , output logic             meas_vld
`endif
);

  logic [W-1:0] r_acc;
  logic         r_alt;
  logic [W:0]   w_next;
  logic [W-1:0] w_next2;

  assign w_next  = {1'b0, r_acc} + {1'b0, n};
  // next < 2*m whenever this is used, so the low W bits are exact
  assign w_next2 = w_next[W-1:0] - m;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc <= '0;
      r_alt <= 1'b0;
      cen   <= 1'b0;
      cen2  <= 1'b0;
      cen2b <= 1'b0;
    end else begin
      cen   <= 1'b0;
      cen2  <= 1'b0;
      cen2b <= 1'b0;
      if (cen_in && !pause) begin
        if (m == '0) begin
          r_acc <= '0;
        end else if (r_acc >= m) begin
          // phase left out of range by a run-time m change
          r_acc <= '0;
          cen   <= 1'b1;
          cen2  <= 1'b1;
          r_alt <= 1'b1;
        end else if (n >= m) begin
          r_acc <= '0;
          cen   <= 1'b1;
          cen2  <= ~r_alt;
          cen2b <= r_alt;
          r_alt <= ~r_alt;
        end else if (w_next >= {1'b0, m}) begin
          r_acc <= w_next2;
          cen   <= 1'b1;
          cen2  <= ~r_alt;
          cen2b <= r_alt;
          r_alt <= ~r_alt;
        end else begin
          r_acc <= w_next[W-1:0];
        end
      end
    end
  end

`ifdef JTFRAME_FRAC_CEN_MEAS_EN
  jtframe_frac_cen_meas #(
    .MEASW    (MEASW)
  ) u_meas (
    .clk      (clk),
    .rst      (rst),
    .cen_in   (cen_in),
    .pause    (pause),
    .cen      (cen),
    .meas     (meas),
    .meas_vld (meas_vld)
  );
`endif

endmodule
`default_nettype wire

// File: tb/tb_jtframe_frac_cen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_jtframe_frac_cen
//  Purpose  : Scoreboard bench for jtframe_frac_cen; expected pulses are
//             queued by the stimulus and popped by the output monitor.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_jtframe_frac_cen;

  localparam int W = 11;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         cen_in = 1'b0;
  logic [W-1:0] n = '0;
  logic [W-1:0] m = '0;
  logic         pause = 1'b0;
  logic         cen, cen2, cen2b;

`ifdef JTFRAME_FRAC_CEN_MEAS_EN
  localparam int MEASW = 8;
  logic [MEASW-1:0] meas;
  logic             meas_vld;
  jtframe_frac_cen #(.W(W), .MEASW(MEASW)) dut (
    .clk(clk), .rst(rst), .cen_in(cen_in), .n(n), .m(m), .pause(pause),
    .cen(cen), .cen2(cen2), .cen2b(cen2b), .meas(meas), .meas_vld(meas_vld)
  );
`else
  jtframe_frac_cen #(.W(W)) dut (
    .clk(clk), .rst(rst), .cen_in(cen_in), .n(n), .m(m), .pause(pause),
    .cen(cen), .cen2(cen2), .cen2b(cen2b)
  );
`endif

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int cyc; bit c2; bit c2b; } exp_t;
  exp_t q[$];

  int checks = 0;
  int failures = 0;
  int seen_total = 0, seen_c2 = 0, seen_c2b = 0;
  int last_c2 = 0, prev_c2 = 0, last_c2b = 0;
  int mi = 0, mk = 0;
  bit alt_m = 1'b0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_pulse();
    q.push_back('{cyc, !alt_m, alt_m});
    alt_m = ~alt_m;
    mk++;
  endtask

  // Pulse k is due on the first cen_in i with i*n >= k*m (n < m),
  // or on every cen_in when n >= m.
  task automatic run_frac(input int nn, input int mm, input int cnt, input int gap);
    n = W'(nn);
    m = W'(mm);
    for (int i = 0; i < cnt; i++) begin
      cen_in = 1'b1;
      tick();
      mi++;
      if (mm != 0) begin
        if (nn >= mm) push_pulse();
        else if (mi * nn >= (mk + 1) * mm) push_pulse();
      end
      cen_in = 1'b0;
      for (int g = 1; g < gap; g++) tick();
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cen_in = 1'b1;
    tick();
    check("pending_pulses", 64'(q.size()), 64'd0);
    q.delete();
    tick();
    check("rst_outputs", {61'd0, cen, cen2, cen2b}, 64'd0);
`ifdef JTFRAME_FRAC_CEN_MEAS_EN
    check("rst_meas", {55'd0, meas, meas_vld}, 64'd0);
`endif
    rst = 1'b0;
    cen_in = 1'b0;
    pause = 1'b0;
    tick();
    mi = 0; mk = 0; alt_m = 1'b0;
  endtask

  always @(negedge clk) begin
    if (cen || cen2 || cen2b) begin
      seen_total++;
      if (cen2)  begin seen_c2++; prev_c2 = last_c2; last_c2 = cyc; end
      if (cen2b) begin seen_c2b++; last_c2b = cyc; end
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_pulse cyc=%0d got cen=%b cen2=%b cen2b=%b want none",
                 cyc, cen, cen2, cen2b);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("pulse", {29'd0, 32'(cyc), cen, cen2, cen2b},
                       {29'd0, 32'(e.cyc), 1'b1, e.c2, e.c2b});
      end
    end
  end

`ifdef JTFRAME_FRAC_CEN_MEAS_EN
  int vcyc[$];
  int vval[$];
  always @(negedge clk) if (meas_vld) begin
    vcyc.push_back(cyc);
    vval.push_back(int'(meas));
  end
`endif

  initial begin
    #1_000_000;
    $display("FAIL watchdog cyc=%0d want finish", cyc);
    $fatal(1);
  end

  initial begin
    int t0, t2, t2b;
    n = W'(105);
    m = W'(1408);
    do_reset();

    // 105/1408 at full rate: first pulse on the 14th cen_in
    t0 = seen_total; t2 = seen_c2; t2b = seen_c2b;
    run_frac(105, 1408, 13, 1);
    check("before_first", {63'd0, cen}, 64'd0);
    run_frac(105, 1408, 1, 1);
    check("first_pulse", {62'd0, cen, cen2}, 64'd3);
    run_frac(105, 1408, 1394, 1);
    @(negedge clk); #1;
    check("ntsc_total", 64'(seen_total - t0), 64'd105);
    check("ntsc_cen2",  64'(seen_c2 - t2),    64'd53);
    check("ntsc_cen2b", 64'(seen_c2b - t2b),  64'd52);

    // 1/2 with cen_in every 4th clk
    do_reset();
    run_frac(1, 2, 16, 4);
    @(negedge clk); #1;
    check("half_c2_period", 64'(last_c2 - prev_c2), 64'd16);
    check("half_c2_c2b_off", 64'(last_c2b - last_c2), 64'd8);

    // Run-time m drop below the current phase
    do_reset();
    run_frac(100, 1408, 13, 1);
    n = W'(30);
    m = W'(100);
    cen_in = 1'b1;
    tick();
    q.push_back('{cyc, 1'b1, 1'b0});
    alt_m = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      if (i == 4) q.push_back('{cyc, 1'b0, 1'b1});
    end
    cen_in = 1'b0;
    tick();

    // n >= m clamps to cen_in, then reset with cen_in high
    do_reset();
    run_frac(5, 3, 10, 1);
    run_frac(5, 3, 5, 3);
    run_frac(5, 3, 1, 1);
    rst = 1'b1;
    cen_in = 1'b1;
    tick();
    check("rst_with_cen_in", {61'd0, cen, cen2, cen2b}, 64'd0);
    do_reset();
    t0 = seen_total;
    run_frac(5, 0, 100, 1);
    @(negedge clk); #1;
    check("m_zero_quiet", 64'(seen_total - t0), 64'd0);

    // Pause mid-run: paused cen_in strobes must not advance the phase
    do_reset();
    run_frac(105, 1408, 20, 1);
    tick();
    t0 = seen_total;
    pause = 1'b1;
    cen_in = 1'b1;
    for (int i = 0; i < 50; i++) tick();
    pause = 1'b0;
    cen_in = 1'b0;
    @(negedge clk); #1;
    check("pause_quiet", 64'(seen_total - t0), 64'd0);
    run_frac(105, 1408, 30, 1);
    @(negedge clk); #1;
    check("pause_resume_total", 64'(mk), 64'd3);

`ifdef JTFRAME_FRAC_CEN_MEAS_EN
    do_reset();
    vcyc.delete();
    vval.delete();
    run_frac(1, 4, 800, 1);
    @(negedge clk); #1;
    check("meas_vld_count", 64'(vcyc.size()), 64'd3);
    if (vcyc.size() >= 3) begin
      check("meas_win2", 64'(vval[1]), 64'd64);
      check("meas_win3", 64'(vval[2]), 64'd64);
      check("meas_period", 64'(vcyc[2] - vcyc[1]), 64'd256);
    end
`endif

    tick();
    check("queue_drained", 64'(q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
